mprj_bram_arbiter: RTL and testbench
====================================

MPRJ_BRAM_ARBITER -- requirements
Module: mprj_bram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, BRAM word-address width (4 KiB).
REQ-002 SHALL have parameter RD_LAT, default 1, BRAM read latency in cycles (1..15).
REQ-003 SHALL have one clock and a synchronous, active-high reset:
  wb_clk_i  in  1  sole clock, all state updates on rising edge
  wb_rst_i  in  1  synchronous active-high reset
REQ-004 SHALL provide the Wishbone slave port, requester 0 (CPU):
  wbs_cyc_i  in  1  bus cycle
  wbs_stb_i  in  1  strobe
  wbs_we_i  in  1  write enable
  wbs_sel_i  in  4  byte selects
  wbs_adr_i  in  32  byte address
  wbs_dat_i  in  32  write data
  wbs_ack_o  out  1  one-cycle acknowledge
  wbs_dat_o  out  32  read data
REQ-005 SHALL provide accelerator ports, requesters 1 (FIR) and 2 (matmul), index k = 0 for FIR, k = 1 for matmul:
  acc_req_i  in  2  request, held until grant
  acc_we_i  in  2  write enable
  acc_addr_i  in  2*ADDR_W  word address, slice k
  acc_wdata_i  in  64  write data, slice k
  acc_gnt_o  out  2  one-cycle grant pulse
  acc_rvalid_o  out  2  one-cycle read-data-valid pulse
  acc_rdata_o  out  32  read data, shared
REQ-006 SHALL provide the single-port BRAM port:
  bram_en_o  out  1  enable
  bram_we_o  out  4  byte write enables
  bram_addr_o  out  ADDR_W  word address
  bram_wdata_o  out  32  write data
  bram_rdata_i  in  32  read data, valid RD_LAT cycles after the enable cycle

Function
REQ-007 CPU request SHALL be eligible only when cyc & stb & wbs_adr_i[31:24]==8'h38; word address = wbs_adr_i[ADDR_W+1:2]; non-matching addresses are never acked.
REQ-008 FSM SHALL have states IDLE, ACCESS, WAIT, RESP.
REQ-009 IDLE: if any request is eligible, grant one round-robin, latch id/we/addr/wdata/sel, and go to ACCESS; otherwise stay in IDLE.
REQ-010 Round-robin: search order starts at (last granted id + 1) mod 3; a waiting requester SHALL be served within 3 transactions.
REQ-011 acc_gnt_o[k] SHALL pulse in the ACCESS cycle of accelerator k's transaction; the accelerator may drop req afterward.
REQ-012 ACCESS: bram_en_o=1 for exactly one cycle, driven from latched fields. bram_we_o = wbs_sel_i for CPU writes, 4'hF for accelerator writes, 0 for reads. Writes go to RESP; reads go to WAIT.
REQ-013 WAIT SHALL last RD_LAT cycles; bram_rdata_i is captured into the read-data register on the last WAIT cycle; then go to RESP.
REQ-014 RESP, one cycle: for CPU, wbs_ack_o=1 with wbs_dat_o = captured data (reads). For accelerator reads, acc_rvalid_o[k]=1 with acc_rdata_o = captured data. Accelerator writes get no rvalid. Next state is IDLE.
REQ-015 Latency from first eligible cycle T0 in IDLE: write ack at T0+2; read ack/rvalid at T0+2+RD_LAT.
REQ-016 Only one transaction SHALL be in flight; requests arriving outside IDLE wait.
REQ-017 If wbs_cyc_i falls before RESP, the BRAM access completes but wbs_ack_o SHALL be suppressed.
REQ-018 An accelerator that drops req before grant SHALL NOT be granted.
REQ-019 wbs_dat_o and acc_rdata_o SHALL hold the last captured value outside RESP.

Reset
REQ-020 On wb_rst_i: state=IDLE; all outputs 0; data registers 0; last-granted pointer=2 (CPU first). Takes effect at the next edge, including mid-transaction; an aborted transaction produces no ack, gnt or rvalid.

Structure
REQ-021 Package mprj_bram_pkg SHALL hold: state enum, requester ids (REQ_CPU=0, REQ_FIR=1, REQ_MM=2), BRAM_BASE=8'h38.
REQ-022 Round-robin selection SHALL be the sub-module rr_arbiter3: request[2:0] and last id in, one-hot grant out, combinational.

Verification
REQ-023 Bench SHALL cover:
- CPU write 0x38000010 = 0x0000002A, sel=F, then read it back -> ack at T0+2 for the write, then read ack at T0+3 (RD_LAT=1) with data 0x2A.
- CPU sel=4'b0010 write 0xFFFFFFFF over 0 -> readback 0x0000FF00.
- All three requesting continuously from reset -> grant order CPU, FIR, MM, CPU; no requester starves.
- FIR read of addr 5 with RD_LAT=3 -> bram_en one cycle, acc_rvalid_o[0] 3 cycles after WAIT entry, data correct.
- wb_rst_i asserted in WAIT -> next cycle IDLE, no ack or rvalid, pointer=2.
- wbs_adr_i=0x30000000 with stb held for 20 cycles -> no ack, no bram_en.

Source files
------------

// File: rtl/mprj_bram_pkg.sv
// Shared types and constants for the user-project BRAM arbiter.
package mprj_bram_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StWait,
    StResp
  } state_e;

  localparam logic [1:0] REQ_CPU = 2'd0;
  localparam logic [1:0] REQ_FIR = 2'd1;
  localparam logic [1:0] REQ_MM  = 2'd2;

  localparam logic [7:0] BRAM_BASE = 8'h38;

  // Successor in the CPU -> FIR -> MM -> CPU rotation.
  function automatic logic [1:0] next_id(input logic [1:0] id);
    return (id == REQ_MM) ? REQ_CPU : id + 2'd1;
  endfunction

  function automatic logic [1:0] onehot_to_id(input logic [2:0] oh);
    logic [1:0] id;
    id = REQ_CPU;
    if (oh[REQ_FIR]) id = REQ_FIR;
    if (oh[REQ_MM])  id = REQ_MM;
    return id;
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin picker: search starts just after the last granted id.
module rr_arbiter3
  import mprj_bram_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic [1:0] last_id_i,
  output logic [2:0] gnt_o
);

  always_comb begin
    logic [1:0] id;
    logic       found;
    gnt_o = '0;
    found = 1'b0;
    id    = next_id(last_id_i);
    for (int i = 0; i < 3; i++) begin
      if (!found && req_i[id]) begin
        gnt_o[id] = 1'b1;
        found     = 1'b1;
      end
      id = next_id(id);
    end
  end

endmodule

// File: rtl/mprj_bram_arbiter.sv
// Single-port BRAM shared by the Wishbone CPU slave and two accelerators;
// round-robin, one transaction in flight at a time.
module mprj_bram_arbiter
  import mprj_bram_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,

  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,

  input  logic [1:0]            acc_req_i,
  input  logic [1:0]            acc_we_i,
  input  logic [2*ADDR_W-1:0]   acc_addr_i,
  input  logic [63:0]           acc_wdata_i,
  output logic [1:0]            acc_gnt_o,
  output logic [1:0]            acc_rvalid_o,
  output logic [31:0]           acc_rdata_o,

  output logic                  bram_en_o,
  output logic [3:0]            bram_we_o,
  output logic [ADDR_W-1:0]     bram_addr_o,
  output logic [31:0]           bram_wdata_o,
  input  logic [31:0]           bram_rdata_i
);

  localparam logic [3:0] WaitLoad = 4'(RD_LAT - 1);

  state_e            state_q, state_d;
  logic [1:0]        id_q, id_d;
  logic [1:0]        last_id_q, last_id_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              cyc_lost_q, cyc_lost_d;

  logic       cpu_elig;
  logic [2:0] req_vec;
  logic [2:0] rr_gnt;
  logic       unused_adr;

  assign cpu_elig   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BRAM_BASE);
  assign req_vec    = {acc_req_i[1], acc_req_i[0], cpu_elig};
  assign unused_adr = ^{wbs_adr_i[23:ADDR_W+2], wbs_adr_i[1:0]};

  rr_arbiter3 u_rr (
    .req_i     (req_vec),
    .last_id_i (last_id_q),
    .gnt_o     (rr_gnt)
  );

  // Read data is held between responses for both requester classes.
  assign wbs_dat_o   = rdata_q;
  assign acc_rdata_o = rdata_q;

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    last_id_d    = last_id_q;
    we_d         = we_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    wait_cnt_d   = wait_cnt_q;
    cyc_lost_d   = cyc_lost_q;
    bram_en_o    = 1'b0;
    bram_we_o    = 4'h0;
    bram_addr_o  = '0;
    bram_wdata_o = '0;
    wbs_ack_o    = 1'b0;
    acc_gnt_o    = 2'b00;
    acc_rvalid_o = 2'b00;

    unique case (state_q)
      StIdle: begin
        if (|req_vec) begin
          id_d       = onehot_to_id(rr_gnt);
          last_id_d  = onehot_to_id(rr_gnt);
          cyc_lost_d = 1'b0;
          state_d    = StAccess;
          unique case (1'b1)
            rr_gnt[REQ_FIR]: begin
              we_d    = acc_we_i[0];
              addr_d  = acc_addr_i[ADDR_W-1:0];
              wdata_d = acc_wdata_i[31:0];
              be_d    = {4{acc_we_i[0]}};
            end
            rr_gnt[REQ_MM]: begin
              we_d    = acc_we_i[1];
              addr_d  = acc_addr_i[2*ADDR_W-1:ADDR_W];
              wdata_d = acc_wdata_i[63:32];
              be_d    = {4{acc_we_i[1]}};
            end
            default: begin
              we_d    = wbs_we_i;
              addr_d  = wbs_adr_i[ADDR_W+1:2];
              wdata_d = wbs_dat_i;
              be_d    = wbs_we_i ? wbs_sel_i : 4'h0;
            end
          endcase
        end
      end

      StAccess: begin
        bram_en_o    = 1'b1;
        bram_we_o    = be_q;
        bram_addr_o  = addr_q;
        bram_wdata_o = wdata_q;
        acc_gnt_o    = {id_q == REQ_MM, id_q == REQ_FIR};
        cyc_lost_d   = cyc_lost_q | ~wbs_cyc_i;
        if (we_q) begin
          state_d = StResp;
        end else begin
          wait_cnt_d = WaitLoad;
          state_d    = StWait;
        end
      end

      StWait: begin
        cyc_lost_d = cyc_lost_q | ~wbs_cyc_i;
        if (wait_cnt_q == 4'd0) begin
          rdata_d = bram_rdata_i;
          state_d = StResp;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end

      StResp: begin
        // A CPU that abandoned the cycle mid-access never sees the ack.
        wbs_ack_o    = (id_q == REQ_CPU) & ~cyc_lost_q & wbs_cyc_i;
        acc_rvalid_o = {id_q == REQ_MM, id_q == REQ_FIR} & {2{~we_q}};
        state_d      = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= StIdle;
      id_q       <= REQ_CPU;
      last_id_q  <= REQ_MM;
      we_q       <= 1'b0;
      be_q       <= 4'h0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      wait_cnt_q <= 4'd0;
      cyc_lost_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      last_id_q  <= last_id_d;
      we_q       <= we_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      wait_cnt_q <= wait_cnt_d;
      cyc_lost_q <= cyc_lost_d;
    end
  end

endmodule

// File: tb/tb_mprj_bram_arbiter.sv
// Directed and randomized checks of mprj_bram_arbiter against a BRAM model
// and a word-level memory/latency/round-robin reference.
module tb_mprj_bram_arbiter;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned RD_LAT = 3;

  logic                wb_clk_i;
  logic                wb_rst_i;
  logic                wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]          wbs_sel_i;
  logic [31:0]         wbs_adr_i, wbs_dat_i;
  logic                wbs_ack_o;
  logic [31:0]         wbs_dat_o;
  logic [1:0]          acc_req_i, acc_we_i;
  logic [2*ADDR_W-1:0] acc_addr_i;
  logic [63:0]         acc_wdata_i;
  logic [1:0]          acc_gnt_o, acc_rvalid_o;
  logic [31:0]         acc_rdata_o;
  logic                bram_en_o;
  logic [3:0]          bram_we_o;
  logic [ADDR_W-1:0]   bram_addr_o;
  logic [31:0]         bram_wdata_o, bram_rdata_i;

  int checks = 0;
  int failures = 0;
  logic [31:0] ref_mem [int];

  mprj_bram_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .wbs_cyc_i    (wbs_cyc_i),
    .wbs_stb_i    (wbs_stb_i),
    .wbs_we_i     (wbs_we_i),
    .wbs_sel_i    (wbs_sel_i),
    .wbs_adr_i    (wbs_adr_i),
    .wbs_dat_i    (wbs_dat_i),
    .wbs_ack_o    (wbs_ack_o),
    .wbs_dat_o    (wbs_dat_o),
    .acc_req_i    (acc_req_i),
    .acc_we_i     (acc_we_i),
    .acc_addr_i   (acc_addr_i),
    .acc_wdata_i  (acc_wdata_i),
    .acc_gnt_o    (acc_gnt_o),
    .acc_rvalid_o (acc_rvalid_o),
    .acc_rdata_o  (acc_rdata_o),
    .bram_en_o    (bram_en_o),
    .bram_we_o    (bram_we_o),
    .bram_addr_o  (bram_addr_o),
    .bram_wdata_o (bram_wdata_o),
    .bram_rdata_i (bram_rdata_i)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  // BRAM with RD_LAT-cycle read pipeline; idle slots carry a poison word.
  logic [31:0] mem  [2**ADDR_W];
  logic [31:0] pipe [RD_LAT];
  always @(posedge wb_clk_i) begin
    if (bram_en_o)
      for (int b = 0; b < 4; b++)
        if (bram_we_o[b]) mem[bram_addr_o][8*b +: 8] <= bram_wdata_o[8*b +: 8];
    pipe[0] <= bram_en_o ? mem[bram_addr_o] : 32'hDEAD_BEEF;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bram_rdata_i = pipe[RD_LAT-1];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Called at a drive point (#1 after a rising edge); cycle n=0 is T0.
  task automatic cpu_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat, input int drop_at, input int max_n,
                          output logic [31:0] rdat, output int ack_n, output int en_cnt,
                          output logic [3:0] en_we, output logic [ADDR_W-1:0] en_addr);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_sel_i = sel; wbs_dat_i = dat;
    ack_n = -1; en_cnt = 0; rdat = '0; en_we = '0; en_addr = '0;
    for (int n = 0; n < max_n; n++) begin
      if (drop_at >= 0) begin
        wbs_cyc_i = (n != drop_at);
        if (n >= drop_at) wbs_stb_i = 1'b0;
      end
      @(negedge wb_clk_i);
      if (bram_en_o) begin en_cnt++; en_we = bram_we_o; en_addr = bram_addr_o; end
      if (wbs_ack_o) begin ack_n = n; rdat = wbs_dat_o; end
      @(posedge wb_clk_i); #1;
      if (ack_n >= 0) break;
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic acc_xfer(input int k, input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [31:0] wdata, input int max_n,
                          output logic [31:0] rdat, output int gnt_n, output int rv_n,
                          output int rv_any, output int en_cnt, output logic [3:0] en_we);
    acc_req_i[k] = 1'b1; acc_we_i[k] = we;
    acc_addr_i[k*ADDR_W +: ADDR_W] = addr; acc_wdata_i[k*32 +: 32] = wdata;
    gnt_n = -1; rv_n = -1; rv_any = 0; en_cnt = 0; rdat = '0; en_we = '0;
    for (int n = 0; n < max_n; n++) begin
      @(negedge wb_clk_i);
      if (bram_en_o) begin en_cnt++; en_we = bram_we_o; end
      if (acc_gnt_o[k]) gnt_n = n;
      if (|acc_rvalid_o) rv_any++;
      if (acc_rvalid_o[k]) begin rv_n = n; rdat = acc_rdata_o; end
      @(posedge wb_clk_i); #1;
      if (gnt_n >= 0) acc_req_i[k] = 1'b0;
      if (rv_n >= 0 || (we && gnt_n >= 0 && n >= gnt_n + 3)) break;
    end
    acc_req_i[k] = 1'b0; acc_we_i[k] = 1'b0;
  endtask

  initial begin
    logic [31:0]       rd;
    logic [31:0]       adr;
    logic [3:0]        en_we;
    logic [ADDR_W-1:0] en_addr;
    int ack_n, gnt_n, rv_n, rv_any, en_cnt;
    int got, acks, ens, last_id, exp_id, nid, order_n;

    wb_rst_i = 1'b1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = '0;
    wbs_adr_i = '0; wbs_dat_i = '0;
    acc_req_i = '0; acc_we_i = '0; acc_addr_i = '0; acc_wdata_i = '0;
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    check("rst_ctrl", {wbs_ack_o, acc_gnt_o, acc_rvalid_o, bram_en_o, bram_we_o}, '0);
    check("rst_wbs_dat", wbs_dat_o, '0);
    check("rst_acc_rdata", acc_rdata_o, '0);
    @(posedge wb_clk_i); #1;

    // CPU write then readback
    cpu_xfer(1'b1, 32'h3800_0010, 4'hF, 32'h0000_002A, -1, 20, rd, ack_n, en_cnt, en_we, en_addr);
    check("cpu_wr_ack_lat", ack_n, 2);
    check("cpu_wr_en_cnt", en_cnt, 1);
    check("cpu_wr_addr", 32'(en_addr), 32'd4);
    ref_mem[4] = 32'h0000_002A;
    cpu_xfer(1'b0, 32'h3800_0010, 4'hF, '0, -1, 20, rd, ack_n, en_cnt, en_we, en_addr);
    check("cpu_rd_ack_lat", ack_n, 2 + RD_LAT);
    check("cpu_rd_data", rd, 32'h0000_002A);
    check("cpu_rd_we", 32'(en_we), '0);

    // Byte-select write
    cpu_xfer(1'b1, 32'h3800_0020, 4'hF, 32'h0, -1, 20, rd, ack_n, en_cnt, en_we, en_addr);
    cpu_xfer(1'b1, 32'h3800_0020, 4'b0010, 32'hFFFF_FFFF, -1, 20, rd, ack_n, en_cnt, en_we,
             en_addr);
    check("sel_wr_we", 32'(en_we), 32'h2);
    cpu_xfer(1'b0, 32'h3800_0020, 4'hF, '0, -1, 20, rd, ack_n, en_cnt, en_we, en_addr);
    check("sel_rd_data", rd, 32'h0000_FF00);
    ref_mem[8] = 32'h0000_FF00;

    // Matmul write, FIR read of word 5
    acc_xfer(1, 1'b1, 10'd5, 32'hC0FF_EE11, 20, rd, gnt_n, rv_n, rv_any, en_cnt, en_we);
    check("mm_wr_gnt_lat", gnt_n, 1);
    check("mm_wr_we", 32'(en_we), 32'hF);
    check("mm_wr_no_rvalid", rv_any, 0);
    ref_mem[5] = 32'hC0FF_EE11;
    acc_xfer(0, 1'b0, 10'd5, '0, 20, rd, gnt_n, rv_n, rv_any, en_cnt, en_we);
    check("fir_rd_gnt_lat", gnt_n, 1);
    check("fir_rd_rvalid_lat", rv_n, 2 + RD_LAT);
    check("fir_rd_en_cnt", en_cnt, 1);
    check("fir_rd_rvalid_cnt", rv_any, 1);
    check("fir_rd_data", rd, 32'hC0FF_EE11);

    // Out-of-window address
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3000_0000;
    acks = 0; ens = 0;
    repeat (20) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) acks++;
      if (bram_en_o) ens++;
      @(posedge wb_clk_i); #1;
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    check("badadr_acks", acks, 0);
    check("badadr_en", ens, 0);

    // cyc dropped during ACCESS: write lands, ack suppressed
    cpu_xfer(1'b1, 32'h3800_0040, 4'hF, 32'h1234_5678, 1, 8, rd, ack_n, en_cnt, en_we, en_addr);
    check("drop_no_ack", ack_n, -1);
    check("drop_en_cnt", en_cnt, 1);
    ref_mem[16] = 32'h1234_5678;
    cpu_xfer(1'b0, 32'h3800_0040, 4'hF, '0, -1, 20, rd, ack_n, en_cnt, en_we, en_addr);
    check("drop_rd_data", rd, 32'h1234_5678);

    // Reset while in WAIT
    acc_req_i[0] = 1'b1; acc_we_i[0] = 1'b0; acc_addr_i[ADDR_W-1:0] = 10'd5;
    got = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge wb_clk_i);
      if (acc_gnt_o[0]) got = 1;
      @(posedge wb_clk_i); #1;
      if (got == 1) break;
    end
    check("rstwait_gnt_seen", got, 1);
    acc_req_i[0] = 1'b0; wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    check("rstwait_ctrl", {wbs_ack_o, acc_gnt_o, acc_rvalid_o, bram_en_o}, '0);
    check("rstwait_rdata", acc_rdata_o, '0);
    @(posedge wb_clk_i); #1;

    // All three requesting from reset: rotation begins with the CPU
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'hF;
    wbs_adr_i = 32'h3800_0050; wbs_dat_i = 32'hA0A0_A0A0;
    acc_req_i = 2'b11; acc_we_i = 2'b11;
    acc_addr_i = {10'd22, 10'd21}; acc_wdata_i = {32'hB2B2_B2B2, 32'hB1B1_B1B1};
    last_id = 2; order_n = 0; acks = 0; rv_any = 0;
    for (int n = 0; n < 80 && order_n < 6; n++) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) acks++;
      if (|acc_rvalid_o) rv_any++;
      if (bram_en_o) begin
        nid = acc_gnt_o[0] ? 1 : (acc_gnt_o[1] ? 2 : 0);
        exp_id = (last_id + 1) % 3;
        check($sformatf("rr_grant%0d", order_n), nid, exp_id);
        last_id = exp_id;
        order_n++;
      end
      @(posedge wb_clk_i); #1;
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; acc_req_i = '0; acc_we_i = '0;
    check("rr_grant_count", order_n, 6);
    check("rr_cpu_acks", acks, 2);
    check("rr_no_rvalid", rv_any, 0);
    repeat (6) @(posedge wb_clk_i);
    #1;
    ref_mem[20] = 32'hA0A0_A0A0;
    ref_mem[21] = 32'hB1B1_B1B1;
    ref_mem[22] = 32'hB2B2_B2B2;

    // Randomized single transactions against the word-level reference
    for (int t = 0; t < 40; t++) begin
      int r;
      logic wr;
      logic [ADDR_W-1:0] wa;
      logic [31:0] wd;
      logic [3:0] sel;
      r   = int'($urandom_range(2, 0));
      wa  = ADDR_W'($urandom_range(31, 0));
      wd  = $urandom;
      sel = 4'($urandom);
      wr  = ($urandom_range(1, 0) == 1) || !ref_mem.exists(int'(wa));
      if (!ref_mem.exists(int'(wa))) sel = 4'hF;
      if (r == 0) begin
        adr = {8'h38, 12'($urandom), wa, 2'($urandom)};
        cpu_xfer(wr, adr, sel, wd, -1, 20, rd, ack_n, en_cnt, en_we, en_addr);
        check("rnd_cpu_addr", 32'(en_addr), 32'(wa));
        if (wr) begin
          check("rnd_cpu_wr_lat", ack_n, 2);
          check("rnd_cpu_wr_we", 32'(en_we), 32'(sel));
          ref_mem[int'(wa)] = merge(ref_mem.exists(int'(wa)) ? ref_mem[int'(wa)] : 32'h0,
                                    wd, sel);
        end else begin
          check("rnd_cpu_rd_lat", ack_n, 2 + RD_LAT);
          check("rnd_cpu_rd_data", rd, ref_mem[int'(wa)]);
        end
      end else begin
        acc_xfer(r - 1, wr, wa, wd, 20, rd, gnt_n, rv_n, rv_any, en_cnt, en_we);
        check("rnd_acc_gnt_lat", gnt_n, 1);
        if (wr) begin
          check("rnd_acc_wr_no_rvalid", rv_any, 0);
          ref_mem[int'(wa)] = wd;
        end else begin
          check("rnd_acc_rd_lat", rv_n, 2 + RD_LAT);
          check("rnd_acc_rd_data", rd, ref_mem[int'(wa)]);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
